// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: state encodings,
// default frame constants and the parity helper.
package uart_pkg;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_SB_TICKS  = 16;
  localparam int MAX_DATA_BITS = 9;

  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_START  = 5'b00010;
  localparam logic [4:0] ST_DATA   = 5'b00100;
  localparam logic [4:0] ST_PARITY = 5'b01000;
  localparam logic [4:0] ST_STOP   = 5'b10000;

  typedef enum logic [4:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } state_e;

  // Expected parity bit for a data word: even -> XOR of data, odd -> inverted.
  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] data,
                                     input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input; resets to 1 so an idle-high
// line never looks like an edge coming out of reset.
module uart_sync2 (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic meta;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      meta   <= 1'b1;
      o_sync <= 1'b1;
    end else begin
      meta   <= i_async;
      o_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable width, oversampling, parity and
// stop bits, driven by an external oversample tick.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int SB_TICKS   = DEF_SB_TICKS,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int TW = $clog2(SB_TICKS);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TC_MID    = TW'(SB_TICKS / 2 - 1);
  localparam logic [TW-1:0] TC_END    = TW'(SB_TICKS - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [BW-1:0] B_ONE     = BW'(1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_e               state, state_nxt;
  logic                 rx_s;
  logic                 armed;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;
  logic                 fr_acc;
  logic                 start_mid, bit_end, fr_now;

  uart_sync2 u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_rx),
    .o_sync  (rx_s)
  );

  assign start_mid = i_tick && (tick_cnt == TC_MID);
  assign bit_end   = i_tick && (tick_cnt == TC_END);
  assign fr_now    = fr_acc | ~rx_s;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (armed && !rx_s) state_nxt = S_START;
      S_START:  if (start_mid) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (bit_end && bit_cnt == LAST_DATA)
                  state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP:   if (bit_end && bit_cnt == LAST_STOP) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= S_IDLE;
      armed        <= 1'b1;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      fr_acc       <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_valid <= 1'b0;
      o_busy  <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          par_acc  <= 1'b0;
          fr_acc   <= 1'b0;
          if (!armed && rx_s) armed <= 1'b1;
        end
        S_START: if (i_tick) tick_cnt <= start_mid ? '0 : tick_cnt + T_ONE;
        S_DATA: if (i_tick) begin
          if (bit_end) begin
            tick_cnt <= '0;
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt  <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + B_ONE;
          end else begin
            tick_cnt <= tick_cnt + T_ONE;
          end
        end
        S_PARITY: if (i_tick) begin
          if (bit_end) begin
            tick_cnt <= '0;
            par_acc  <= parity_of(MAX_DATA_BITS'(shreg), 1'(PARITY_ODD)) ^ rx_s;
          end else begin
            tick_cnt <= tick_cnt + T_ONE;
          end
        end
        S_STOP: if (i_tick) begin
          if (bit_end) begin
            tick_cnt <= '0;
            fr_acc   <= fr_now;
            bit_cnt  <= bit_cnt + B_ONE;
            if (bit_cnt == LAST_STOP) begin
              o_data       <= shreg;
              o_parity_err <= (PARITY_EN != 0) ? par_acc : 1'b0;
              o_frame_err  <= fr_now;
              o_valid      <= 1'b1;
              // A low stop bit usually means a break; wait for the line to go high.
              armed        <= ~fr_now;
            end
          end else begin
            tick_cnt <= tick_cnt + T_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1, 8E1 and 7N2 instances on a shared
// clock, reset and oversample tick (one tick every 4 clocks, 16 ticks per bit).
module tb_uart_rx_param;

  localparam int BIT_CLKS = 64;

  logic clk = 1'b0;
  logic rst, tick;
  logic rx_a, rx_p, rx_w;
  logic [1:0] div = 2'd0;

  logic [7:0] da, dp;
  logic [6:0] dw;
  logic va, pea, fea, ba;
  logic vp, pep, fep, bp;
  logic vw, pew, few, bw;

  int vectors = 0;
  int miscompares = 0;
  int cnt_a = 0, cnt_p = 0, cnt_w = 0;
  logic [8:0] qw[$];

  uart_rx_param dut_a (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx_a),
    .o_data(da), .o_valid(va), .o_parity_err(pea), .o_frame_err(fea), .o_busy(ba));

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx_p),
    .o_data(dp), .o_valid(vp), .o_parity_err(pep), .o_frame_err(fep), .o_busy(bp));

  uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) dut_w (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx_w),
    .o_data(dw), .o_valid(vw), .o_parity_err(pew), .o_frame_err(few), .o_busy(bw));

  initial forever #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (div == 2'd3);
      div  = div + 2'd1;
    end
  end

  always @(negedge clk) begin
    if (va === 1'b1) cnt_a++;
    if (vp === 1'b1) cnt_p++;
    if (vw === 1'b1) begin
      cnt_w++;
      qw.push_back({pew, few, dw});
    end
  end

  task automatic set_rx(input int which, input logic b);
    case (which)
      0: rx_a = b;
      1: rx_p = b;
      default: rx_w = b;
    endcase
  endtask

  // bits[0] goes on the line first; line is left at 'rest' afterwards.
  task automatic send_frame(input int which, input logic [15:0] bits,
                            input int n, input logic rest);
    for (int i = 0; i < n; i++) begin
      set_rx(which, bits[i]);
      repeat (BIT_CLKS) @(negedge clk);
    end
    set_rx(which, rest);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_a = 1'b1; rx_p = 1'b1; rx_w = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (da !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", da); end
    vectors++; if (va !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", va); end
    vectors++; if (pea !== 1'b0) begin miscompares++; $display("FAIL reset_perr got %b want 0", pea); end
    vectors++; if (fea !== 1'b0) begin miscompares++; $display("FAIL reset_ferr got %b want 0", fea); end
    vectors++; if ({ba, bp, bw} !== 3'b000) begin miscompares++; $display("FAIL reset_busy got %b want 000", {ba, bp, bw}); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_basic;
    int n0;
    n0 = cnt_a;
    send_frame(0, {1'b1, 8'hA5, 1'b0}, 10, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if (cnt_a !== n0 + 1) begin miscompares++; $display("FAIL basic_count got %0d want %0d", cnt_a, n0 + 1); end
    vectors++; if (da !== 8'hA5) begin miscompares++; $display("FAIL basic_data got %h want a5", da); end
    vectors++; if ({pea, fea} !== 2'b00) begin miscompares++; $display("FAIL basic_errs got %b want 00", {pea, fea}); end
    vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL basic_busy got %b want 0", ba); end
  endtask

  task automatic test_parity;
    int n0;
    n0 = cnt_p;
    send_frame(1, {1'b1, 1'b0, 8'h3C, 1'b0}, 11, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if (cnt_p !== n0 + 1) begin miscompares++; $display("FAIL par_ok_count got %0d want %0d", cnt_p, n0 + 1); end
    vectors++; if (dp !== 8'h3C) begin miscompares++; $display("FAIL par_ok_data got %h want 3c", dp); end
    vectors++; if ({pep, fep} !== 2'b00) begin miscompares++; $display("FAIL par_ok_errs got %b want 00", {pep, fep}); end
    send_frame(1, {1'b1, 1'b1, 8'h3C, 1'b0}, 11, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if (cnt_p !== n0 + 2) begin miscompares++; $display("FAIL par_bad_count got %0d want %0d", cnt_p, n0 + 2); end
    vectors++; if (dp !== 8'h3C) begin miscompares++; $display("FAIL par_bad_data got %h want 3c", dp); end
    vectors++; if ({pep, fep} !== 2'b10) begin miscompares++; $display("FAIL par_bad_errs got %b want 10", {pep, fep}); end
  endtask

  task automatic test_glitch;
    int n0;
    n0 = cnt_a;
    rx_a = 1'b0;
    repeat (16) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    vectors++; if (cnt_a !== n0) begin miscompares++; $display("FAIL glitch_count got %0d want %0d", cnt_a, n0); end
    vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL glitch_busy got %b want 0", ba); end
    vectors++; if (da !== 8'hA5) begin miscompares++; $display("FAIL glitch_hold got %h want a5", da); end
  endtask

  task automatic test_frame_err;
    int n0;
    n0 = cnt_a;
    send_frame(0, {1'b0, 8'h55, 1'b0}, 10, 1'b0);
    repeat (3 * BIT_CLKS) @(negedge clk);
    vectors++; if (cnt_a !== n0 + 1) begin miscompares++; $display("FAIL ferr_count got %0d want %0d", cnt_a, n0 + 1); end
    vectors++; if (da !== 8'h55) begin miscompares++; $display("FAIL ferr_data got %h want 55", da); end
    vectors++; if ({pea, fea} !== 2'b01) begin miscompares++; $display("FAIL ferr_errs got %b want 01", {pea, fea}); end
    vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL ferr_break_busy got %b want 0", ba); end
    rx_a = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    vectors++; if (cnt_a !== n0 + 1) begin miscompares++; $display("FAIL ferr_rearm_count got %0d want %0d", cnt_a, n0 + 1); end
    send_frame(0, {1'b1, 8'h5A, 1'b0}, 10, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if (da !== 8'h5A) begin miscompares++; $display("FAIL ferr_recover_data got %h want 5a", da); end
    vectors++; if (fea !== 1'b0) begin miscompares++; $display("FAIL ferr_recover_flag got %b want 0", fea); end
  endtask

  task automatic test_reset_mid;
    int n0;
    n0 = cnt_a;
    rx_a = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx_a = 1'b1;
    repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    vectors++; if (ba !== 1'b1) begin miscompares++; $display("FAIL rmid_busy_before got %b want 1", ba); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vectors++; if (da !== 8'h00) begin miscompares++; $display("FAIL rmid_data got %h want 00", da); end
    vectors++; if ({va, pea, fea, ba} !== 4'b0000) begin miscompares++; $display("FAIL rmid_flags got %b want 0000", {va, pea, fea, ba}); end
    repeat (6 * BIT_CLKS) @(negedge clk);
    vectors++; if (cnt_a !== n0) begin miscompares++; $display("FAIL rmid_no_valid got %0d want %0d", cnt_a, n0); end
    send_frame(0, {1'b1, 8'h81, 1'b0}, 10, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if (cnt_a !== n0 + 1) begin miscompares++; $display("FAIL rmid_after_count got %0d want %0d", cnt_a, n0 + 1); end
    vectors++; if (da !== 8'h81) begin miscompares++; $display("FAIL rmid_after_data got %h want 81", da); end
  endtask

  task automatic test_back_to_back;
    int n0;
    logic [8:0] e0, e1;
    qw.delete();
    n0 = cnt_w;
    send_frame(2, {2'b11, 7'h7F, 1'b0}, 10, 1'b1);
    send_frame(2, {2'b11, 7'h00, 1'b0}, 10, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if (cnt_w !== n0 + 2) begin miscompares++; $display("FAIL b2b_count got %0d want %0d", cnt_w, n0 + 2); end
    e0 = (qw.size() > 0) ? qw[0] : 9'h1FF;
    e1 = (qw.size() > 1) ? qw[1] : 9'h1FF;
    vectors++; if (e0 !== {2'b00, 7'h7F}) begin miscompares++; $display("FAIL b2b_first got %h want 07f", e0); end
    vectors++; if (e1 !== {2'b00, 7'h00}) begin miscompares++; $display("FAIL b2b_second got %h want 000", e1); end
    vectors++; if (bw !== 1'b0) begin miscompares++; $display("FAIL b2b_busy got %b want 0", bw); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_glitch;
    test_frame_err;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Configurable data width, oversampling ratio, optional parity and 1 or 2 stop bits.
- Runs off an external baud-rate oversample enable (i_tick) and synchronises the asynchronous line internally.
- Reports each received word with a one-cycle valid pulse plus parity/framing error flags; sits between the pin and the UART interface/FIFO logic.

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9, LSB first.
- SB_TICKS, 16, i_tick pulses per bit period, even, legal 8..64.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1, number of stop bits, legal 1 or 2.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_tick  in  1  oversample enable, one-clock pulse, SB_TICKS per bit.
- i_rx  in  1  asynchronous serial line, idle high.
- o_data  out  DATA_BITS  last received word.
- o_valid  out  1  one-clock pulse when o_data/error flags update.
- o_parity_err  out  1  parity mismatch on last word.
- o_frame_err  out  1  a stop bit sampled low on last word.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock domain (i_clock); reset is synchronous and active-high on i_reset.
- Input synchronisation: i_rx passes through a 2-FF synchroniser; both FFs reset to 1. rx_s denotes the synchronised value. Add 2 clocks of input latency.
- Reset values: o_data=0, o_valid=0, o_parity_err=0, o_frame_err=0, o_busy=0, state=IDLE, all counters=0, armed=1.
- Reset mid-frame: abandons the frame on the next edge with no o_valid, and returns to IDLE.
- Counting: tick_cnt width is clog2(SB_TICKS); bit_cnt width is clog2(DATA_BITS). Both counters advance only on clocks where i_tick=1. All states except IDLE ignore rx_s when i_tick=0.

State machine (one-hot, registered state, separate next-state logic):
- IDLE:
  - If armed=0, set armed=1 when rx_s=1.
  - If armed=1 and rx_s=0: go to START with tick_cnt=0. No i_tick is needed for this transition.
- START:
  - On each tick, tick_cnt++.
  - When tick_cnt = SB_TICKS/2-1 on a tick: if rx_s=0, go to DATA with tick_cnt=0 and bit_cnt=0. If rx_s=1, treat it as a glitch and go to IDLE with no output.
- DATA:
  - On each tick, tick_cnt++.
  - When tick_cnt = SB_TICKS-1 on a tick (mid-bit): shift rx_s into the MSB of the shift register (right shift, LSB first), set tick_cnt=0, bit_cnt++.
  - After bit DATA_BITS-1 is sampled: go to PARITY if PARITY_EN, else go to STOP.
- PARITY:
  - Sample at tick_cnt = SB_TICKS-1.
  - par_err = (XOR of data bits) XOR rx_s XOR PARITY_ODD. Then go to STOP.
- STOP:
  - Sample rx_s at tick_cnt = SB_TICKS-1 of each stop bit. fr_err is the OR of (rx_s=0) over all stop bits.
  - After the last stop-bit sample: load o_data, o_parity_err (0 if !PARITY_EN) and o_frame_err; pulse o_valid on the next clock; go to IDLE.
  - If fr_err=1, clear armed so a held-low line (break) does not retrigger.

Outputs:
- o_valid pulses regardless of errors.
- o_data and the error flags hold until the next o_valid.

Boundary conditions:
- i_tick coinciding with the start edge in IDLE is not counted.
- i_tick held high every clock is legal (continuous oversampling).
- Back-to-back frames: a falling edge on the same clock as the IDLE entry starts the next frame when armed=1.

Decomposition:
- Package uart_pkg:
  - State encoding localparams ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP.
  - Default constants DEF_DATA_BITS=8 and DEF_SB_TICKS=16.
  - A function for parity calculation.
- Sub-module uart_sync2: 2-FF synchroniser, reset value 1, reusable by other async inputs.

Test Plan:
- Default 8N1, SB_TICKS=16, i_tick every 4 clocks, send 0xA5 -> one o_valid with o_data=0xA5, o_parity_err=0, o_frame_err=0, o_busy low afterwards.
- PARITY_EN=1, even parity, send 0x3C with parity bit 0 -> o_data=0x3C, parity_err=0. Resend 0x3C with parity bit 1 -> parity_err=1.
- Send 0x55 with stop bit forced low, then hold the line low for 3 bit times -> o_valid with frame_err=1, and no second frame until the line returns high.
- Low pulse of 4 ticks on an idle line -> returns to IDLE, no o_valid.
- Assert i_reset in the middle of data bit 4 of 0xFF -> no o_valid, all outputs 0. Then send 0x81 -> o_data=0x81.
- DATA_BITS=7, STOP_BITS=2: send 0x7F then immediately 0x00 -> two o_valid pulses with o_data 0x7F then 0x00, no errors.
